// File: rtl/multicycle_cu_pkg.sv
// multicycle_cu_pkg: shared definitions for the multi-cycle LEGv8 control unit.
// Holds the FSM state, instruction class and fault encodings, the ALU and SEU
// operation codes, and a helper that maps an instruction class to the ALU-side
// datapath controls (SEU format, ALU B source, ALU op, register-2 source).
package multicycle_cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_e;

    typedef enum logic [4:0] {
        CLS_NOP, CLS_B, CLS_CBZ, CLS_CBNZ,
        CLS_ADDI, CLS_ANDI, CLS_EORI, CLS_ORRI, CLS_SUBI,
        CLS_ADD, CLS_AND, CLS_EOR, CLS_LSL, CLS_LSR, CLS_ORR, CLS_SUB,
        CLS_LDUR, CLS_STUR
    } class_e;

    typedef enum logic [1:0] {
        FAULT_NONE, FAULT_ILLEGAL, FAULT_IMEM, FAULT_DMEM
    } fault_e;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_ORR    = 3'b011;
    localparam logic [2:0] ALU_EOR    = 3'b100;
    localparam logic [2:0] ALU_LSL    = 3'b101;
    localparam logic [2:0] ALU_LSR    = 3'b110;
    localparam logic [2:0] ALU_PASS_B = 3'b111;

    localparam logic [1:0] SEU_B  = 2'b00;
    localparam logic [1:0] SEU_CB = 2'b01;
    localparam logic [1:0] SEU_I  = 2'b10;
    localparam logic [1:0] SEU_D  = 2'b11;

    typedef struct packed {
        logic [1:0] seu_op;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       reg_2_loc;
    } alu_ctrl_t;

    // ALU-side controls for a class. B and NOP leave everything at zero.
    // LSL/LSR take the shift amount from shamt, so reg_2_loc/alu_src stay 0.
    function automatic alu_ctrl_t class_ctrl(input class_e cls);
        alu_ctrl_t c;
        c = '0;
        case (cls)
            CLS_CBZ, CLS_CBNZ: begin
                c.seu_op    = SEU_CB;
                c.alu_op    = ALU_PASS_B;
                c.reg_2_loc = 1'b1;
            end
            CLS_ADDI, CLS_SUBI, CLS_ANDI, CLS_ORRI, CLS_EORI: begin
                c.seu_op  = SEU_I;
                c.alu_src = 1'b1;
                case (cls)
                    CLS_SUBI: c.alu_op = ALU_SUB;
                    CLS_ANDI: c.alu_op = ALU_AND;
                    CLS_ORRI: c.alu_op = ALU_ORR;
                    CLS_EORI: c.alu_op = ALU_EOR;
                    default:  c.alu_op = ALU_ADD;
                endcase
            end
            CLS_ADD: c.alu_op = ALU_ADD;
            CLS_SUB: c.alu_op = ALU_SUB;
            CLS_AND: c.alu_op = ALU_AND;
            CLS_ORR: c.alu_op = ALU_ORR;
            CLS_EOR: c.alu_op = ALU_EOR;
            CLS_LSL: c.alu_op = ALU_LSL;
            CLS_LSR: c.alu_op = ALU_LSR;
            CLS_LDUR, CLS_STUR: begin
                c.seu_op    = SEU_D;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
                c.reg_2_loc = (cls == CLS_STUR);
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_cu_if.sv
// multicycle_cu_if: bundle between the control unit and the datapath/memories.
// master: the control unit (drives strobes, mux selects, fault, retired;
//         receives op_code, zero, imem_ready, dmem_ready).
// slave:  the datapath/memory side, mirror image of master.
interface multicycle_cu_if #(
    parameter int OPCODE_W = 11,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] op_code;
    logic                zero;
    logic                imem_req;
    logic                imem_ready;
    logic                dmem_req;
    logic                dmem_ready;
    logic                ir_wr;
    logic                pc_wr;
    logic                pc_src;
    logic                reg_2_loc;
    logic [1:0]          seu_op;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_wr;
    logic                mem_to_reg;
    logic                reg_wr;
    logic [1:0]          fault;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  op_code, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, ir_wr, pc_wr, pc_src, reg_2_loc, seu_op,
               alu_src, alu_op, mem_wr, mem_to_reg, reg_wr, fault, retired
    );

    modport slave (
        output op_code, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, ir_wr, pc_wr, pc_src, reg_2_loc, seu_op,
               alu_src, alu_op, mem_wr, mem_to_reg, reg_wr, fault, retired
    );
endinterface

// File: rtl/multicycle_cu_op_classify.sv
// multicycle_cu_op_classify: combinational LEGv8 opcode decoder.
// Ports: op_code (in)  - IR opcode field instr[31:21]
//        cls     (out) - instruction class (CLS_NOP when illegal)
//        illegal (out) - no supported encoding matched
module multicycle_cu_op_classify
    import multicycle_cu_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] op_code,
    output class_e              cls,
    output logic                illegal
);
    always_comb begin
        cls     = CLS_NOP;
        illegal = 1'b0;
        casez (op_code)
            11'b000101?????: cls = CLS_B;
            11'b10110100???: cls = CLS_CBZ;
            11'b10110101???: cls = CLS_CBNZ;
            11'b1001000100?: cls = CLS_ADDI;
            11'b1001001000?: cls = CLS_ANDI;
            11'b1101001000?: cls = CLS_EORI;
            11'b1011001000?: cls = CLS_ORRI;
            11'b1101000100?: cls = CLS_SUBI;
            11'b10001011000: cls = CLS_ADD;
            11'b10001010000: cls = CLS_AND;
            11'b11001010000: cls = CLS_EOR;
            11'b11010011011: cls = CLS_LSL;
            11'b11010011010: cls = CLS_LSR;
            11'b10101010000: cls = CLS_ORR;
            11'b11001011000: cls = CLS_SUB;
            11'b11111000010: cls = CLS_LDUR;
            11'b11111000000: cls = CLS_STUR;
            default:         illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle LEGv8 control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and mux selects,
// handshakes with imem/dmem (req/ready with MEM_TIMEOUT wait limit), counts
// retired instructions and traps stickily on illegal opcode or memory timeout.
// Ports: clk, reset (sync, active-high); bus (multicycle_cu_if.master) carrying
// op_code/zero/ready inputs and all control, fault and retired outputs.
module multicycle_cu
    import multicycle_cu_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic           clk,
    input  logic           reset,
    multicycle_cu_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    class_e            class_q, class_d;
    fault_e            fault_q, fault_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    class_e    dec_cls;
    logic      dec_illegal;
    alu_ctrl_t ctrl;
    logic      imem_req, dmem_req, ir_wr, pc_wr, pc_src, mem_wr, mem_to_reg, reg_wr;

    multicycle_cu_op_classify #(.OPCODE_W(OPCODE_W)) u_classify (
        .op_code (bus.op_code),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        fault_d    = fault_q;
        wait_d     = wait_q;
        retired_d  = retired_q;
        ctrl       = '0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_wr   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_IMEM;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    class_d = dec_cls;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ctrl = class_ctrl(class_q);
                case (class_q)
                    CLS_B: begin
                        pc_wr   = 1'b1;
                        pc_src  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    // Branch decision is the only combinational path from zero.
                    CLS_CBZ, CLS_CBNZ: begin
                        pc_wr   = 1'b1;
                        pc_src  = (class_q == CLS_CBZ) ? bus.zero : ~bus.zero;
                        state_d = ST_FETCH;
                    end
                    CLS_LDUR, CLS_STUR: state_d = ST_MEM;
                    default:            state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                ctrl     = class_ctrl(class_q);
                dmem_req = 1'b1;
                mem_wr   = (class_q == CLS_STUR);
                if (bus.dmem_ready) begin
                    if (class_q == CLS_STUR) begin
                        pc_wr   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_DMEM;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB: begin
                // ALU controls stay valid so a combinational ALU result can be written.
                ctrl       = class_ctrl(class_q);
                reg_wr     = 1'b1;
                mem_to_reg = (class_q == CLS_LDUR);
                pc_wr      = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_FETCH;
        endcase

        // Every state change (including the one taken on ready) restarts the wait count.
        if (state_d != state_q) begin
            wait_d = '0;
        end

        // Reset outranks the state decode so an aborted instruction issues nothing.
        if (reset) begin
            ctrl       = '0;
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            ir_wr      = 1'b0;
            pc_wr      = 1'b0;
            pc_src     = 1'b0;
            mem_wr     = 1'b0;
            mem_to_reg = 1'b0;
            reg_wr     = 1'b0;
        end

        if (pc_wr) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            class_q   <= CLS_NOP;
            fault_q   <= FAULT_NONE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            fault_q   <= fault_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.dmem_req   = dmem_req;
    assign bus.ir_wr      = ir_wr;
    assign bus.pc_wr      = pc_wr;
    assign bus.pc_src     = pc_src;
    assign bus.reg_2_loc  = ctrl.reg_2_loc;
    assign bus.seu_op     = ctrl.seu_op;
    assign bus.alu_src    = ctrl.alu_src;
    assign bus.alu_op     = ALU_OP_W'(ctrl.alu_op);
    assign bus.mem_wr     = mem_wr;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_wr     = reg_wr;
    assign bus.fault      = fault_q;
    assign bus.retired    = retired_q;

endmodule
